// File: rtl/instr_encoder_loader_if.sv
// Request and instruction-memory write bus of the instruction encoder/loader.
// master: the encoder (accepts requests, drives memory writes).
// slave:  the environment (issues requests, acts as the memory write port).
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_cmd;
  logic [1:0]        in_ra;
  logic [1:0]        in_rb;
  logic [1:0]        in_rc;
  logic [3:0]        in_imm;
  logic [3:0]        in_cond;
  logic              im_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [8:0]        im_wdata;

  modport master (
    input  in_valid, in_cmd, in_ra, in_rb, in_rc, in_imm, in_cond, im_ready,
    output in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    output in_valid, in_cmd, in_ra, in_rb, in_rc, in_imm, in_cond, im_ready,
    input  in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Instruction encoder/loader: packs symbolic requests into 9-bit machine
// words, buffers them in a small FIFO and writes them to sequential
// instruction-memory addresses.
// Optional feature macro: ENC_CHKSUM_EN (running XOR of written words).
module instr_encoder_loader #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  instr_encoder_loader_if.master         bus,
  output logic                           busy,
  output logic                           err,
  output logic                           wrapped,
  output logic [8:0]                     chksum
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [8:0]        mem_q [DEPTH];
  logic              enc_valid_q, enc_valid_d;
  logic [8:0]        enc_word_q, enc_word_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              wrapped_q, wrapped_d;

  logic              enc_legal;
  logic [8:0]        enc_word;
  logic [3:0]        neg_imm;
  logic [3:0]        alu_sel;
  logic              accept, push, pop;

  // Combinational encoder: request fields -> machine word plus legality
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    neg_imm   = 4'd0 - bus.in_imm;
    alu_sel   = bus.in_cmd - 4'd5;
    case (bus.in_cmd)
      4'd0, 4'd1: begin
        enc_word  = {2'b00, bus.in_cmd[0], bus.in_rc, bus.in_ra, bus.in_imm[1:0]};
        enc_legal = (bus.in_imm[3:2] == 2'b00);
      end
      4'd2: enc_word = {3'b010, bus.in_rc, bus.in_imm};
      4'd3: begin
        enc_word  = {3'b011, bus.in_rc, bus.in_imm};
        enc_legal = !bus.in_imm[3];
      end
      4'd4: begin
        // Right shift is a left shift by the two's-complement amount
        enc_word  = {3'b011, bus.in_rc, neg_imm};
        enc_legal = (bus.in_imm != 4'd0) && (bus.in_imm <= 4'd8);
      end
      4'd5, 4'd6, 4'd7, 4'd8: enc_word = {3'b100, alu_sel[1:0], bus.in_ra, bus.in_rb};
      4'd9:  enc_word = {3'b101, 2'b00, bus.in_ra, bus.in_rb};
      4'd10: begin
        // Codes 0-3 collide with the CMP/simple-arith space; 9 is unused
        enc_word  = {3'b101, bus.in_cond, bus.in_rb};
        enc_legal = (bus.in_cond >= 4'd4) && (bus.in_cond != 4'd9);
      end
      4'd11: enc_word = {3'b110, 2'b00, bus.in_ra, bus.in_rb};
      4'd12: enc_word = {3'b111, 2'b00, bus.in_ra, bus.in_rb};
      default: enc_legal = 1'b0;
    endcase
  end

  // Handshake and write-port outputs; encode stage counts against capacity
  always_comb begin
    bus.in_ready = rst_n && !start &&
                   ((int'(count_q) + int'(enc_valid_q)) < DEPTH);
    bus.im_we    = (count_q != '0);
    bus.im_wdata = bus.im_we ? mem_q[rd_ptr_q] : 9'd0;
    bus.im_addr  = addr_q;
    busy         = enc_valid_q || (count_q != '0);
    err          = err_q;
    wrapped      = wrapped_q;
  end

  // Next-state: start overrides everything, otherwise push/pop/encode
  always_comb begin
    accept      = bus.in_valid && bus.in_ready;
    push        = enc_valid_q;
    pop         = bus.im_we && bus.im_ready;
    enc_valid_d = enc_valid_q;
    enc_word_d  = enc_word_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    addr_d      = addr_q;
    err_d       = err_q;
    wrapped_d   = wrapped_q;
    if (start) begin
      enc_valid_d = 1'b0;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      addr_d      = ADDR_W'(BASE_ADDR);
      err_d       = 1'b0;
      wrapped_d   = 1'b0;
    end else begin
      enc_valid_d = accept && enc_legal;
      if (accept && enc_legal) enc_word_d = enc_word;
      if (accept && !enc_legal) err_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        addr_d   = addr_q + 1'b1;
        if (&addr_q) wrapped_d = 1'b1;
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_valid_q <= 1'b0;
      enc_word_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      addr_q      <= ADDR_W'(BASE_ADDR);
      err_q       <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      enc_valid_q <= enc_valid_d;
      enc_word_q  <= enc_word_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      wrapped_q   <= wrapped_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (push && !start) mem_q[wr_ptr_q] <= enc_word_q;
  end

`ifdef ENC_CHKSUM_EN
  logic [8:0] chk_q, chk_d;

  // Running XOR of every completed write
  always_comb begin
    chk_d = chk_q;
    if (start)    chk_d = 9'd0;
    else if (pop) chk_d = chk_q ^ bus.im_wdata;
  end

  // Checksum register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_q <= 9'd0;
    else        chk_q <= chk_d;
  end

  assign chksum = chk_q;
`else
  assign chksum = 9'd0;
`endif
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed scenarios followed
// by randomized traffic, compared against a queue-based reference model.
module tb_instr_encoder_loader;
  localparam int DEPTH  = 4;
  localparam int AW     = 3;
  localparam int AMASK  = (1 << AW) - 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, err, wrapped;
  logic [8:0] chksum;

  instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

  instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .err(err), .wrapped(wrapped), .chksum(chksum)
  );

  always #5 clk = ~clk;

  typedef struct { int word; int edge_idx; } exp_t;
  exp_t q[$];
  int   m_addr, m_err, m_wrapped, m_chk, edge_cnt;
  int   n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference encoding computed from the instruction-set rules with arithmetic
  function automatic int ref_enc(input int cmd, ra, rb, rc, imm, cond, output bit legal);
    legal = 1'b1;
    case (cmd)
      0, 1: begin legal = (imm < 4); return cmd * 64 + rc * 16 + ra * 4 + (imm % 4); end
      2:    return 128 + rc * 16 + imm;
      3:    begin legal = (imm <= 7); return 192 + rc * 16 + imm; end
      4:    begin legal = (imm >= 1 && imm <= 8); return 192 + rc * 16 + ((16 - imm) % 16); end
      5, 6, 7, 8: return 256 + (cmd - 5) * 16 + ra * 4 + rb;
      9:    return 320 + ra * 4 + rb;
      10:   begin legal = (cond >= 4 && cond != 9); return 320 + cond * 4 + rb; end
      11:   return 384 + ra * 4 + rb;
      12:   return 448 + ra * 4 + rb;
      default: begin legal = 1'b0; return 0; end
    endcase
  endfunction

  function automatic void model_clear();
    q.delete();
    m_addr = 0; m_err = 0; m_wrapped = 0; m_chk = 0;
  endfunction

  task automatic check_reset_values();
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_im_we", bus.im_we, 0);
    check_eq("rst_im_addr", bus.im_addr, 0);
    check_eq("rst_im_wdata", bus.im_wdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_wrapped", wrapped, 0);
    check_eq("rst_chksum", chksum, 0);
  endtask

  // One clock: drive at negedge, check, then advance the model at posedge
  task automatic cycle(input bit st, input bit v, input int cmd, input int ra, input int rb,
                       input int rc, input int imm, input int cond, input bit imr, output bit acc);
    bit exp_ready, exp_we, legal;
    int w;
    @(negedge clk);
    start = st; bus.in_valid = v; bus.in_cmd = cmd[3:0]; bus.in_ra = ra[1:0];
    bus.in_rb = rb[1:0]; bus.in_rc = rc[1:0]; bus.in_imm = imm[3:0];
    bus.in_cond = cond[3:0]; bus.im_ready = imr;
    #1;
    exp_ready = !st && (q.size() < DEPTH);
    exp_we    = (q.size() > 0) && (q[0].edge_idx < edge_cnt);
    check_eq("in_ready", bus.in_ready, exp_ready);
    check_eq("im_we", bus.im_we, exp_we);
    check_eq("im_addr", bus.im_addr, m_addr);
    check_eq("busy", busy, q.size() > 0);
    check_eq("err", err, m_err);
    check_eq("wrapped", wrapped, m_wrapped);
`ifdef ENC_CHKSUM_EN
    check_eq("chksum", chksum, m_chk);
`else
    check_eq("chksum", chksum, 0);
`endif
    if (exp_we) check_eq("im_wdata", bus.im_wdata, q[0].word);
    acc = v && exp_ready;
    @(posedge clk);
    edge_cnt++;
    if (st) begin
      model_clear();
    end else begin
      if (exp_we && imr) begin
        m_chk ^= q[0].word;
        if (m_addr == AMASK) m_wrapped = 1;
        m_addr = (m_addr + 1) & AMASK;
        void'(q.pop_front());
      end
      if (acc) begin
        w = ref_enc(cmd, ra, rb, rc, imm, cond, legal);
        if (legal) q.push_back('{word: w, edge_idx: edge_cnt});
        else       m_err = 1;
      end
    end
  endtask

  task automatic idle(input int n, input bit imr);
    bit a;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, imr, a);
  endtask

  bit acc;
  int tries;

  initial begin
    rst_n = 1'b0; start = 1'b0; edge_cnt = 0;
    bus.in_valid = 0; bus.in_cmd = 0; bus.in_ra = 0; bus.in_rb = 0; bus.in_rc = 0;
    bus.in_imm = 0; bus.in_cond = 0; bus.im_ready = 0;
    model_clear();
    #3 check_reset_values();
    @(negedge clk) rst_n = 1'b1;

    // start, then MOV rc=2 imm=5 written two cycles after acceptance
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, acc);
    cycle(0, 1, 2, 0, 0, 2, 5, 0, 1, acc);
    idle(3, 1);
    // SHR by 8 (legal) then by 9 (dropped, err)
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, acc);
    cycle(0, 1, 4, 0, 0, 1, 8, 0, 1, acc);
    cycle(0, 1, 4, 0, 0, 1, 9, 0, 1, acc);
    idle(3, 1);
    // BRC with illegal then legal condition
    cycle(0, 1, 10, 0, 3, 0, 0, 9, 1, acc);
    cycle(0, 1, 10, 0, 3, 0, 0, 6, 1, acc);
    idle(3, 1);

    // Backpressure: DEPTH+2 requests retried until accepted, memory stalled first
    tries = 0;
    for (int k = 0; k < DEPTH + 2; k++) begin
      acc = 0;
      while (!acc && tries < 40) begin
        cycle(0, 1, 2, 0, 0, k % 4, k, 0, tries > 10, acc);
        tries++;
      end
      if (!acc) check_eq("accept_timeout", 0, 1);
    end
    idle(8, 1);

    // Randomized traffic, with occasional start pulses and varying backpressure
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15),
            (i < 750) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2), acc);
    end

    // Asynchronous reset in the middle of traffic drops everything
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_values();
    model_clear();
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle(0, $urandom_range(0, 1), $urandom_range(0, 12), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 1), acc);
    end
    idle(10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
